// File: rtl/mulpop_scheduler_pkg.sv
// Shared types and constants for the multiply/popcount scheduler.
package mulpop_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [1:0] ST_OK  = 2'b11;
   localparam logic [1:0] ST_OVF = 2'b10;
   localparam logic [1:0] ST_TMO = 2'b00;

   localparam int DEF_OPW = 24;   // operand width
   localparam int W_W     = 32;   // result W width
   localparam int L_W     = 24;   // ones-count L width

   // Captured response payload, held in RESP until consumed.
   typedef struct packed {
      logic [W_W-1:0] w;
      logic [L_W-1:0] l;
      logic [1:0]     status;
   } rsp_t;

endpackage

// File: rtl/mulpop_scheduler_if.sv
// Requester, datapath and response signals of the scheduler.
interface mulpop_scheduler_if
   import mulpop_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int OPW  = DEF_OPW,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]           req_valid;
   logic [NREQ-1:0]           req_ready;
   logic [NREQ-1:0][OPW-1:0]  req_a1;
   logic [NREQ-1:0][OPW-1:0]  req_a2;

   logic                      dp_start;
   logic [OPW-1:0]            dp_a1;
   logic [OPW-1:0]            dp_a2;
   logic                      dp_done;
   logic [W_W-1:0]            dp_w;
   logic [L_W-1:0]            dp_l;
   logic                      dp_ovf;

   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [IDW-1:0]            rsp_id;
   logic [W_W-1:0]            rsp_w;
   logic [L_W-1:0]            rsp_l;
   logic [1:0]                rsp_status;
   logic [15:0]               op_count;
   logic                      busy;

   // Scheduler side.
   modport slave (
      input  req_valid, req_a1, req_a2, dp_done, dp_w, dp_l, dp_ovf, rsp_ready,
      output req_ready, dp_start, dp_a1, dp_a2, rsp_valid, rsp_id, rsp_w,
             rsp_l, rsp_status, op_count, busy
   );

   // Requesters plus datapath, seen from outside the scheduler.
   modport master (
      output req_valid, req_a1, req_a2, dp_done, dp_w, dp_l, dp_ovf, rsp_ready,
      input  req_ready, dp_start, dp_a1, dp_a2, rsp_valid, rsp_id, rsp_w,
             rsp_l, rsp_status, op_count, busy
   );
endinterface

// File: rtl/mulpop_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  id
);
   logic [IDW:0] pos;
   logic         found;

   // Scan NREQ positions starting at ptr; first hit wins.
   always_comb begin
      grant = '0;
      id    = '0;
      found = 1'b0;
      pos   = '0;
      for (int k = 0; k < NREQ; k++) begin
         pos = {1'b0, ptr} + (IDW+1)'(k);
         if (pos >= (IDW+1)'(NREQ)) pos = pos - (IDW+1)'(NREQ);
         if (en && !found && req[pos[IDW-1:0]]) begin
            grant[pos[IDW-1:0]] = 1'b1;
            id                  = pos[IDW-1:0];
            found               = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mulpop_scheduler.sv
// Round-robin scheduler for a shared multiply/popcount datapath with timeout.
module mulpop_scheduler
   import mulpop_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int OPW     = DEF_OPW,
   parameter int TIMEOUT = 64,
   parameter int IDW     = $clog2(NREQ)
) (
   input logic          clk,
   input logic          reset,
   mulpop_scheduler_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t          state, state_nx;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  gid;
   logic [OPW-1:0]  a1, a2;
   logic [TW-1:0]   timer;
   rsp_t            rsp_q;
   logic [15:0]     cnt;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  gnt_id;
   logic            expire;

   // Grants only offered from IDLE and never while reset is held.
   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .en    (state == IDLE && !reset),
      .grant (grant),
      .id    (gnt_id)
   );

   assign expire = (timer == TW'(TIMEOUT - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic; dp_done takes priority over the expiry check.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (|grant) state_nx = ISSUE;
         ISSUE: state_nx = WAIT;
         WAIT:  if (bus.dp_done || expire) state_nx = RESP;
         RESP:  if (bus.rsp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand latch, timer, result capture, counter and fairness pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr   <= '0;
         gid   <= '0;
         a1    <= '0;
         a2    <= '0;
         timer <= '0;
         rsp_q <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (|grant) begin
               a1  <= bus.req_a1[gnt_id];
               a2  <= bus.req_a2[gnt_id];
               gid <= gnt_id;
            end
            ISSUE: timer <= '0;
            WAIT: begin
               timer <= timer + 1'b1;
               if (bus.dp_done)
                  rsp_q <= '{w: bus.dp_w, l: bus.dp_l,
                             status: bus.dp_ovf ? ST_OVF : ST_OK};
               else if (expire)
                  rsp_q <= '{w: '0, l: '0, status: ST_TMO};
            end
            RESP: if (bus.rsp_ready) begin
               if (rsp_q.status != ST_TMO) cnt <= cnt + 16'd1;
               ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready  = grant;
   assign bus.dp_start   = (state == ISSUE);
   assign bus.dp_a1      = a1;
   assign bus.dp_a2      = a2;
   assign bus.rsp_valid  = (state == RESP);
   assign bus.rsp_id     = gid;
   assign bus.rsp_w      = rsp_q.w;
   assign bus.rsp_l      = rsp_q.l;
   assign bus.rsp_status = rsp_q.status;
   assign bus.op_count   = cnt;
   assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_mulpop_scheduler.sv
// Bench for mulpop_scheduler: transaction-level model plus directed scenarios.
module tb_mulpop_scheduler;
   import mulpop_pkg::*;

   localparam int NREQ    = 2;
   localparam int OPW     = 24;
   localparam int TIMEOUT = 64;
   localparam int IDW     = 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mulpop_scheduler_if #(.NREQ(NREQ), .OPW(OPW), .IDW(IDW)) bus();

   mulpop_scheduler #(.NREQ(NREQ), .OPW(OPW), .TIMEOUT(TIMEOUT), .IDW(IDW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- datapath model ----------------
   int             dp_lat = 4;
   bit             dp_hang = 1'b0;
   int             stray_req = 0;
   int             stray_seen = 0;
   int             pend = 0;
   logic [OPW-1:0] la1, la2;
   logic [47:0]    dpp;

   // Answers each dp_start after dp_lat cycles; can hang or emit a stray done.
   always @(posedge clk) begin
      #2;
      bus.dp_done = 1'b0;
      if (pend > 0) begin
         pend--;
         if (pend == 0) begin
            dpp         = {24'b0, la1} * {24'b0, la2};
            bus.dp_done = 1'b1;
            bus.dp_w    = dpp[31:0];
            bus.dp_l    = 24'($countones(dpp[31:0]));
            bus.dp_ovf  = |dpp[47:32];
         end
      end
      if (stray_req != stray_seen) begin
         stray_seen  = stray_req;
         bus.dp_done = 1'b1;
         bus.dp_w    = '1;
         bus.dp_l    = '1;
         bus.dp_ovf  = 1'b0;
      end
      if (bus.dp_start && !dp_hang) begin
         pend = dp_lat;
         la1  = bus.dp_a1;
         la2  = bus.dp_a2;
      end
   end

   // ---------------- reference model ----------------
   bit              armed = 1'b0;
   bit              m_busy = 1'b0;
   int              m_ptr = 0;
   logic [15:0]     m_cnt = '0;
   int              t = 0, t_hs = 0, t_rsp = -1;
   int              m_id = 0;
   logic [OPW-1:0]  m_a1, m_a2;
   logic [31:0]     m_w, e_w;
   logic [23:0]     m_l, e_l;
   logic [1:0]      m_st, e_st;
   logic [47:0]     mp;
   logic [IDW-1:0]  sel;
   logic [NREQ-1:0] exp_rdy;
   bit              exp_rv;
   int              glog[$];
   int              last_id = -1;
   logic [31:0]     last_w;
   logic [23:0]     last_l;
   logic [1:0]      last_st;

   function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++)
         if (v[(p + k) % NREQ]) return NREQ'(1) << ((p + k) % NREQ);
      return '0;
   endfunction

   function automatic int onehot_idx(input logic [NREQ-1:0] v);
      for (int k = 0; k < NREQ; k++) if (v[k]) return k;
      return 0;
   endfunction

   // Compare DUT against the transaction model each cycle, then advance the model.
   always @(negedge clk) begin
      t++;
      exp_rdy = (m_busy || reset) ? '0 : rr_pick(bus.req_valid, m_ptr);
      exp_rv  = m_busy && t_rsp >= 0 && t >= t_rsp;
      if (armed) begin
         check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
         check("busy", 64'(bus.busy), 64'(m_busy));
         check("dp_start", 64'(bus.dp_start), 64'(m_busy && t == t_hs + 1));
         if (m_busy && t == t_hs + 1) begin
            check("dp_a1", 64'(bus.dp_a1), 64'(m_a1));
            check("dp_a2", 64'(bus.dp_a2), 64'(m_a2));
         end
         check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
         if (exp_rv) begin
            check("rsp_id", 64'(bus.rsp_id), 64'(m_id));
            check("rsp_w", 64'(bus.rsp_w), 64'(e_w));
            check("rsp_l", 64'(bus.rsp_l), 64'(e_l));
            check("rsp_status", 64'(bus.rsp_status), 64'(e_st));
         end
         check("op_count", 64'(bus.op_count), 64'(m_cnt));
      end
      if (reset) begin
         armed  = 1'b1;
         m_busy = 1'b0;
         m_ptr  = 0;
         m_cnt  = '0;
         t_rsp  = -1;
      end else if (!m_busy) begin
         if (exp_rdy != '0) begin
            m_busy = 1'b1;
            m_id   = onehot_idx(exp_rdy);
            sel    = IDW'(m_id);
            m_a1   = bus.req_a1[sel];
            m_a2   = bus.req_a2[sel];
            mp     = {24'b0, m_a1} * {24'b0, m_a2};
            m_w    = mp[31:0];
            m_l    = 24'($countones(mp[31:0]));
            m_st   = (mp[47:32] != '0) ? 2'b10 : 2'b11;
            t_hs   = t;
            t_rsp  = -1;
            glog.push_back(m_id);
         end
      end else begin
         if (t_rsp < 0) begin
            if (bus.dp_done && t >= t_hs + 2) begin
               t_rsp = t + 1;
               e_w = m_w; e_l = m_l; e_st = m_st;
            end else if (t == t_hs + 1 + TIMEOUT) begin
               t_rsp = t + 1;
               e_w = '0; e_l = '0; e_st = 2'b00;
            end
         end else if (t >= t_rsp && bus.rsp_ready) begin
            if (e_st != 2'b00) m_cnt = m_cnt + 16'd1;
            m_ptr   = (m_id + 1) % NREQ;
            m_busy  = 1'b0;
            last_id = m_id; last_w = e_w; last_l = e_l; last_st = e_st;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [NREQ-1:0] v);
      bus.req_valid = v;
      step();
      bus.req_valid = '0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (bus.busy && n < budget) begin
         step();
         n++;
      end
      check(name, 64'(bus.busy), 64'(0));
   endtask

   initial begin
      int base;
      int n;
      bus.req_valid = '0;
      bus.req_a1    = '0;
      bus.req_a2    = '0;
      bus.rsp_ready = 1'b1;
      reset = 1'b1;
      repeat (3) step();
      check("rst_op_count", 64'(bus.op_count), 64'(0));
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check("rst_dp_start", 64'(bus.dp_start), 64'(0));
      check("rst_rsp_w", 64'(bus.rsp_w), 64'(0));
      check("rst_dp_a1", 64'(bus.dp_a1), 64'(0));
      reset = 1'b0;
      step();

      // single request 3*5
      bus.req_a1[0] = 24'd3; bus.req_a2[0] = 24'd5;
      op(2'b01);
      wait_idle(40, "single_done");
      check("single_id", 64'(last_id), 64'(0));
      check("single_w", 64'(last_w), 64'(32'h0000000F));
      check("single_l", 64'(last_l), 64'(4));
      check("single_st", 64'(last_st), 64'(2'b11));
      check("single_cnt", 64'(bus.op_count), 64'(1));

      // overflow from requester 1 (pointer now 1)
      bus.req_a1[1] = 24'hFFFFFF; bus.req_a2[1] = 24'hFFFFFF;
      op(2'b10);
      wait_idle(40, "ovf_done");
      check("ovf_id", 64'(last_id), 64'(1));
      check("ovf_w", 64'(last_w), 64'(32'hFE000001));
      check("ovf_l", 64'(last_l), 64'(8));
      check("ovf_st", 64'(last_st), 64'(2'b10));
      check("ovf_cnt", 64'(bus.op_count), 64'(2));

      // fairness: both requesters continuously asking, 6 grants
      bus.req_a1[0] = 24'd7;       bus.req_a2[0] = 24'd9;
      bus.req_a1[1] = 24'h123456;  bus.req_a2[1] = 24'h10;
      base = glog.size();
      bus.req_valid = 2'b11;
      n = 0;
      while (glog.size() < base + 6 && n < 300) begin
         step();
         n++;
      end
      bus.req_valid = '0;
      check("fair_grants", 64'(glog.size()), 64'(base + 6));
      wait_idle(40, "fair_done");
      for (int k = 0; k < 6; k++)
         if (base + k < glog.size())
            check("fair_order", 64'(glog[base + k]), 64'(k % 2));
      check("fair_cnt", 64'(bus.op_count), 64'(8));

      // timeout: datapath never answers
      dp_hang = 1'b1;
      bus.req_a1[0] = 24'd11; bus.req_a2[0] = 24'd13;
      op(2'b01);
      wait_idle(150, "tmo_done");
      dp_hang = 1'b0;
      check("tmo_st", 64'(last_st), 64'(2'b00));
      check("tmo_w", 64'(last_w), 64'(0));
      check("tmo_l", 64'(last_l), 64'(0));
      check("tmo_cnt", 64'(bus.op_count), 64'(8));
      stray_req++;
      repeat (5) step();
      check("stray_busy", 64'(bus.busy), 64'(0));
      check("stray_rv", 64'(bus.rsp_valid), 64'(0));
      check("stray_cnt", 64'(bus.op_count), 64'(8));

      // backpressure on requester 1: 100*200 = 0x4E20, five ones
      bus.rsp_ready = 1'b0;
      bus.req_a1[1] = 24'd100; bus.req_a2[1] = 24'd200;
      op(2'b10);
      bus.req_valid = 2'b11;
      n = 0;
      while (!bus.rsp_valid && n < 40) begin
         step();
         n++;
      end
      check("bp_reach", 64'(bus.rsp_valid), 64'(1));
      repeat (10) begin
         step();
         check("bp_rv", 64'(bus.rsp_valid), 64'(1));
         check("bp_w", 64'(bus.rsp_w), 64'(32'h4E20));
         check("bp_l", 64'(bus.rsp_l), 64'(5));
         check("bp_id", 64'(bus.rsp_id), 64'(1));
         check("bp_rdy", 64'(bus.req_ready), 64'(0));
         check("bp_busy", 64'(bus.busy), 64'(1));
      end
      bus.rsp_ready = 1'b1;
      bus.req_valid = '0;
      wait_idle(10, "bp_done");
      check("bp_cnt", 64'(bus.op_count), 64'(9));

      // move pointer to 1, then reset in the middle of WAIT
      bus.req_a1[0] = 24'd2; bus.req_a2[0] = 24'd2;
      op(2'b01);
      wait_idle(40, "pre_rst_done");
      check("pre_rst_cnt", 64'(bus.op_count), 64'(10));
      dp_lat = 20;
      op(2'b10);
      repeat (5) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rw_cnt", 64'(bus.op_count), 64'(0));
      check("rw_busy", 64'(bus.busy), 64'(0));
      check("rw_rv", 64'(bus.rsp_valid), 64'(0));
      check("rw_rsp_w", 64'(bus.rsp_w), 64'(0));
      check("rw_dp_a1", 64'(bus.dp_a1), 64'(0));
      repeat (25) step();
      check("rw_late_done_cnt", 64'(bus.op_count), 64'(0));
      dp_lat = 4;
      base = glog.size();
      op(2'b11);
      check("rw_grant_cnt", 64'(glog.size()), 64'(base + 1));
      if (glog.size() > base)
         check("rw_next_grant", 64'(glog[base]), 64'(0));
      wait_idle(40, "rw_after_done");
      check("rw_after_cnt", 64'(bus.op_count), 64'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule
